// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C byte receiver.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned ADDR_W = 7;

  localparam logic [ADDR_W-1:0] SLAVE_ADDR_DEFAULT = 7'b1111000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK
  } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one raw bus line, plus a history flop for edges.
module i2c_sync_edge (
  input  logic clk,
  input  logic n_rst,
  input  logic din,
  output logic level,
  output logic level_prev,
  output logic rise_c,
  output logic fall_c
);

  logic meta;

  // Resets to 1 so an idle bus out of reset shows no edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta       <= 1'b1;
      level      <= 1'b1;
      level_prev <= 1'b1;
    end else begin
      meta       <= din;
      level      <= meta;
      level_prev <= level;
    end
  end

  assign rise_c = level & ~level_prev;
  assign fall_c = ~level & level_prev;

endmodule

// File: rtl/i2c_rx_byte.sv
// I2C slave receive path: START/STOP detection, address match, data bytes.
module i2c_rx_byte
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = SLAVE_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              scl,
  input  logic              sda_in,
  output logic [BYTE_W-1:0] rx_data,
  output logic              byte_received,
  output logic              start_found,
  output logic              stop_found,
  output logic              address_match,
  output logic              rw_mode,
  output logic              ack_req
);

  logic scl_lvl, scl_prev, scl_rise, scl_fall;
  logic sda_lvl, sda_prev, sda_rise, sda_fall;

  i2c_sync_edge u_scl_sync (
    .clk        (clk),
    .n_rst      (n_rst),
    .din        (scl),
    .level      (scl_lvl),
    .level_prev (scl_prev),
    .rise_c     (scl_rise),
    .fall_c     (scl_fall)
  );

  i2c_sync_edge u_sda_sync (
    .clk        (clk),
    .n_rst      (n_rst),
    .din        (sda_in),
    .level      (sda_lvl),
    .level_prev (sda_prev),
    .rise_c     (sda_rise),
    .fall_c     (sda_fall)
  );

  logic scl_high_c, start_c, stop_c;
  assign scl_high_c = scl_lvl & scl_prev;
  assign start_c    = scl_high_c & sda_fall;
  assign stop_c     = scl_high_c & sda_rise;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [BYTE_W-1:0]  shift, shift_d;
  logic               byte_done, byte_done_d;
  logic [BYTE_W-1:0]  rx_data_d;
  logic               byte_received_d, start_found_d, stop_found_d;
  logic               address_match_d, rw_mode_d, ack_req_d;

  // State and all registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      shift         <= '0;
      byte_done     <= 1'b0;
      rx_data       <= '0;
      byte_received <= 1'b0;
      start_found   <= 1'b0;
      stop_found    <= 1'b0;
      address_match <= 1'b0;
      rw_mode       <= 1'b0;
      ack_req       <= 1'b0;
    end else begin
      state         <= state_d;
      cnt           <= cnt_d;
      shift         <= shift_d;
      byte_done     <= byte_done_d;
      rx_data       <= rx_data_d;
      byte_received <= byte_received_d;
      start_found   <= start_found_d;
      stop_found    <= stop_found_d;
      address_match <= address_match_d;
      rw_mode       <= rw_mode_d;
      ack_req       <= ack_req_d;
    end
  end

  // Next state; STOP beats START beats SCL edges.
  always_comb begin
    state_d         = state;
    cnt_d           = cnt;
    shift_d         = shift;
    byte_done_d     = byte_done;
    rx_data_d       = rx_data;
    byte_received_d = 1'b0;
    start_found_d   = 1'b0;
    stop_found_d    = 1'b0;
    address_match_d = address_match;
    rw_mode_d       = rw_mode;
    ack_req_d       = ack_req;

    if (stop_c) begin
      state_d         = ST_IDLE;
      stop_found_d    = 1'b1;
      address_match_d = 1'b0;
      ack_req_d       = 1'b0;
      byte_done_d     = 1'b0;
    end else if (start_c) begin
      state_d         = ST_ADDR;
      start_found_d   = 1'b1;
      cnt_d           = '0;
      address_match_d = 1'b0;
      ack_req_d       = 1'b0;
      byte_done_d     = 1'b0;
    end else begin
      unique case (state)
        ST_ADDR, ST_DATA: begin
          if (scl_rise) begin
            shift_d = {shift[BYTE_W-2:0], sda_lvl};
            cnt_d   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(7)) begin
              byte_done_d = 1'b1;
              if (state == ST_ADDR) begin
                rw_mode_d       = sda_lvl;
                address_match_d = (shift[ADDR_W-1:0] == SLAVE_ADDR) && !sda_lvl;
              end else begin
                rx_data_d       = {shift[BYTE_W-2:0], sda_lvl};
                byte_received_d = 1'b1;
              end
            end
          end else if (scl_fall && byte_done) begin
            byte_done_d = 1'b0;
            if (state == ST_DATA) begin
              state_d   = ST_DATA_ACK;
              ack_req_d = 1'b1;
            end else if (address_match) begin
              state_d   = ST_ADDR_ACK;
              ack_req_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        // The fall that entered this state counts as the first; the
        // ACK clock's own fall is the second and ends the ACK.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            state_d     = ST_DATA;
            cnt_d       = '0;
            ack_req_d   = 1'b0;
            byte_done_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
